// File: rtl/ed25519_in_unpack.sv
// ed25519 input front-end.
// Collects 12 MSB-first 64-bit stream words (scalar, Px, Py) into three
// 256-bit operands. The operands are then offered to the core over one
// parallel valid/ready handshake. While Px and Py stream in, a single serial
// comparator checks each of them against p = 2^255-19.
module ed25519_in_unpack #(
  parameter int DATA_W = 64,
  parameter int PATN_W = 256,
  parameter int N_OPS  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_abort,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [PATN_W-1:0] o_scalar,
  output logic [PATN_W-1:0] o_px,
  output logic [PATN_W-1:0] o_py,
  output logic              o_coord_err
);

  localparam int WPO     = PATN_W / DATA_W;
  localparam int N_WORDS = N_OPS * WPO;

  localparam logic [3:0] LAST_WORD_IDX = 4'(N_WORDS - 1);
  localparam logic [3:0] LAST_PX_IDX   = 4'(2 * WPO - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_r;
  logic [3:0] wcnt_r;
  logic       trk_dec_r;
  logic       trk_ge_r;
  logic       err_x_r;

  logic [1:0] op_sel_s;
  logic [1:0] sub_s;
  logic [7:0] slice_lo_s;
  logic       accept_s;
  logic [DATA_W-1:0] p_word_s;
  logic       cur_dec_s;
  logic       cur_ge_s;
  logic       nxt_dec_s;
  logic       nxt_ge_s;
  logic       coord_ge_s;

  // Word of p = 2^255-19 at position idx, MSB word first.
  function automatic logic [63:0] p_word(input logic [1:0] idx);
    logic [63:0] w;
    case (idx)
      2'd0:    w = 64'h7FFF_FFFF_FFFF_FFFF;
      2'd1:    w = 64'hFFFF_FFFF_FFFF_FFFF;
      2'd2:    w = 64'hFFFF_FFFF_FFFF_FFFF;
      2'd3:    w = 64'hFFFF_FFFF_FFFF_FFED;
      default: w = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return w;
  endfunction

  // Word placement, accept qualification and the serial >= p comparison step.
  always_comb begin
    op_sel_s   = wcnt_r[3:2];
    sub_s      = wcnt_r[1:0];
    slice_lo_s = {2'd3 - sub_s, 6'd0};
    accept_s   = (state_r == FILL) && i_in_valid;
    p_word_s   = p_word(sub_s);

    // The tracker restarts on the first word of every coordinate.
    if (sub_s == 2'd0) begin
      cur_dec_s = 1'b0;
      cur_ge_s  = 1'b0;
    end else begin
      cur_dec_s = trk_dec_r;
      cur_ge_s  = trk_ge_r;
    end

    if (cur_dec_s) begin
      nxt_dec_s = 1'b1;
      nxt_ge_s  = cur_ge_s;
    end else if (i_in_data > p_word_s) begin
      nxt_dec_s = 1'b1;
      nxt_ge_s  = 1'b1;
    end else if (i_in_data < p_word_s) begin
      nxt_dec_s = 1'b1;
      nxt_ge_s  = 1'b0;
    end else begin
      nxt_dec_s = 1'b0;
      nxt_ge_s  = 1'b0;
    end

    // Still undecided after the last word means the value equals p exactly.
    if (sub_s == 2'd3) begin
      coord_ge_s = nxt_dec_s ? nxt_ge_s : 1'b1;
    end else begin
      coord_ge_s = 1'b0;
    end
  end

  // Control FSM together with the operand, tracker and error registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= FILL;
      wcnt_r      <= 4'd0;
      trk_dec_r   <= 1'b0;
      trk_ge_r    <= 1'b0;
      err_x_r     <= 1'b0;
      o_in_ready  <= 1'b1;
      o_op_valid  <= 1'b0;
      o_coord_err <= 1'b0;
      o_scalar    <= '0;
      o_px        <= '0;
      o_py        <= '0;
    end else if (i_abort) begin
      // An abort drops the job. Operand registers keep their contents.
      state_r     <= FILL;
      wcnt_r      <= 4'd0;
      trk_dec_r   <= 1'b0;
      trk_ge_r    <= 1'b0;
      err_x_r     <= 1'b0;
      o_in_ready  <= 1'b1;
      o_op_valid  <= 1'b0;
      o_coord_err <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            case (op_sel_s)
              2'd0:    o_scalar[slice_lo_s +: DATA_W] <= i_in_data;
              2'd1:    o_px[slice_lo_s +: DATA_W]     <= i_in_data;
              2'd2:    o_py[slice_lo_s +: DATA_W]     <= i_in_data;
              default: begin end
            endcase
            trk_dec_r <= nxt_dec_s;
            trk_ge_r  <= nxt_ge_s;
            if (wcnt_r == LAST_PX_IDX) begin
              err_x_r <= coord_ge_s;
            end
            if (wcnt_r == LAST_WORD_IDX) begin
              state_r     <= HOLD;
              wcnt_r      <= 4'd0;
              o_in_ready  <= 1'b0;
              o_op_valid  <= 1'b1;
              o_coord_err <= err_x_r | coord_ge_s;
            end else begin
              wcnt_r <= wcnt_r + 4'd1;
            end
          end
        end
        HOLD: begin
          if (i_op_ready) begin
            state_r     <= FILL;
            wcnt_r      <= 4'd0;
            trk_dec_r   <= 1'b0;
            trk_ge_r    <= 1'b0;
            err_x_r     <= 1'b0;
            o_in_ready  <= 1'b1;
            o_op_valid  <= 1'b0;
            o_coord_err <= 1'b0;
          end
        end
        default: begin
          state_r     <= FILL;
          wcnt_r      <= 4'd0;
          o_in_ready  <= 1'b1;
          o_op_valid  <= 1'b0;
          o_coord_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ed25519_in_unpack.sv
// Directed bench for ed25519_in_unpack. Inputs are driven and outputs are
// sampled on the falling edge. The DUT acts on the rising edge.
module tb_ed25519_in_unpack;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         abort;
  logic         op_valid;
  logic         op_ready;
  logic [255:0] scalar;
  logic [255:0] px;
  logic [255:0] py;
  logic         coord_err;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] P = {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFED};
  localparam logic [255:0] K1 = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
  localparam logic [255:0] BY = 256'h6666666666666666666666666666666666666666666666666666666666666658;
  localparam logic [255:0] ONES = {256{1'b1}};

  ed25519_in_unpack dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_abort     (abort),
    .o_op_valid  (op_valid),
    .i_op_ready  (op_ready),
    .o_scalar    (scalar),
    .o_px        (px),
    .o_py        (py),
    .o_coord_err (coord_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Feed the first nw words of job {k,x,y}. Returns on a falling edge with valid low.
  task automatic feed(input logic [255:0] k, input logic [255:0] x, input logic [255:0] y,
                      input bit rnd, input int nw);
    logic [767:0] job;
    int w;
    int guard;
    bit acc;
    job = {k, x, y};
    w = 0;
    guard = 0;
    while (w < nw && guard < 2000) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? job[767 - 64*w -: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (rnd) op_ready = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) w++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    op_ready = 1'b0;
    if (w < nw) begin
      checks++;
      failures++;
      $error("FAIL feed_timeout observed=%0d expected=%0d", w, nw);
    end
  endtask

  task automatic check_job(input string tag, input logic [255:0] k, input logic [255:0] x,
                           input logic [255:0] y, input logic err);
    chk1({tag, "_op_valid"}, op_valid, 1'b1);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk256({tag, "_scalar"}, scalar, k);
    chk256({tag, "_px"}, px, x);
    chk256({tag, "_py"}, py, y);
    chk1({tag, "_err"}, coord_err, err);
  endtask

  task automatic handshake_now(input string tag);
    op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_ready = 1'b0;
    chk1({tag, "_hs_op_valid"}, op_valid, 1'b0);
    chk1({tag, "_hs_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_hs_err"}, coord_err, 1'b0);
  endtask

  task automatic rand256(output logic [255:0] v);
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
  endtask

  initial begin
    logic [255:0] rk, rx, ry;
    bit done;
    int guard;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 64'd0;
    abort = 1'b0;
    op_ready = 1'b0;
    #12;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_op_valid", op_valid, 1'b0);
    chk1("rst_err", coord_err, 1'b0);
    chk256("rst_scalar", scalar, 256'd0);
    chk256("rst_px", px, 256'd0);
    chk256("rst_py", py, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Basic load, handshake in the first HOLD cycle.
    feed(K1, 256'd9, BY, 1'b0, 12);
    check_job("basic", K1, 256'd9, BY, 1'b0);
    handshake_now("basic");

    // 2. Backpressure for 20 cycles, then a second job.
    feed(BY, K1, 256'd5, 1'b0, 12);
    for (int i = 0; i < 20; i++) begin
      chk1("bp_op_valid", op_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk256("bp_scalar", scalar, BY);
      chk256("bp_px", px, K1);
      in_valid = 1'b1;
      in_data = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk256("bp_py", py, 256'd5);
    handshake_now("bp");
    feed(256'd77, 256'd1, 256'd2, 1'b0, 12);
    check_job("bp2", 256'd77, 256'd1, 256'd2, 1'b0);
    handshake_now("bp2");

    // 3. Range boundaries.
    feed(K1, P - 256'd1, 256'd0, 1'b0, 12);
    check_job("pm1", K1, P - 256'd1, 256'd0, 1'b0);
    handshake_now("pm1");
    feed(K1, P, 256'd0, 1'b0, 12);
    check_job("peq", K1, P, 256'd0, 1'b1);
    handshake_now("peq");
    feed(K1, 256'd0, ONES, 1'b0, 12);
    check_job("pyones", K1, 256'd0, ONES, 1'b1);
    handshake_now("pyones");
    feed(K1, 256'd0, P + 256'd1, 1'b0, 12);
    check_job("pyp1", K1, 256'd0, P + 256'd1, 1'b1);
    handshake_now("pyp1");

    // 4. Random valid/ready, three jobs.
    for (int j = 0; j < 3; j++) begin
      rand256(rk);
      rand256(rx);
      rand256(ry);
      feed(rk, rx, ry, 1'b1, 12);
      check_job("rnd", rk, rx, ry, (rx >= P) || (ry >= P));
      done = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        chk1("rnd_hold_valid", op_valid, 1'b1);
        chk256("rnd_hold_py", py, ry);
        op_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        done = op_ready;
        guard++;
        @(negedge clk);
      end
      op_ready = 1'b0;
      chk1("rnd_hs_done", done, 1'b1);
      chk1("rnd_after_valid", op_valid, 1'b0);
    end

    // 5a. Abort at wcnt=7 with Px already known to be >= p.
    feed(K1, ONES, ONES, 1'b0, 7);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk1("ab7_in_ready", in_ready, 1'b1);
    chk1("ab7_op_valid", op_valid, 1'b0);
    feed(256'd3, 256'd9, BY, 1'b0, 12);
    check_job("ab7", 256'd3, 256'd9, BY, 1'b0);
    handshake_now("ab7");

    // 5b. Abort after err_x has latched (10 words of a Px=p job).
    feed(K1, P, 256'd0, 1'b0, 10);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    feed(256'd4, 256'd9, 256'd6, 1'b0, 12);
    check_job("ab10", 256'd4, 256'd9, 256'd6, 1'b0);
    handshake_now("ab10");

    // 5c. Abort coincident with an accept drops that word.
    feed(K1, K1, K1, 1'b0, 3);
    in_valid = 1'b1;
    in_data = 64'hBAD0_BAD0_BAD0_BAD0;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    feed(BY, 256'd8, K1, 1'b0, 12);
    check_job("abacc", BY, 256'd8, K1, 1'b0);

    // 5d. Abort beats a simultaneous op handshake.
    op_ready = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    op_ready = 1'b0;
    chk1("abhs_op_valid", op_valid, 1'b0);
    chk1("abhs_in_ready", in_ready, 1'b1);

    // 6. Asynchronous reset after 5 words.
    feed(256'd11, 256'd12, 256'd13, 1'b0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mrst_in_ready", in_ready, 1'b1);
    chk1("mrst_op_valid", op_valid, 1'b0);
    chk256("mrst_scalar", scalar, 256'd0);
    chk256("mrst_py", py, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("mrst_rel_ready", in_ready, 1'b1);
    feed(K1, 256'd9, BY, 1'b0, 12);
    check_job("mrst", K1, 256'd9, BY, 1'b0);
    handshake_now("mrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
